// File: rtl/segled_pkg.sv
// segled_pkg: shared types and constants for the seven-segment serial driver.
// Optional feature macro used by the driver: SEGLED_AUTO_REFRESH_EN.
package segled_pkg;

    // Transfer FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Default frame width: 8 digits x 8 segments.
    localparam int SEG_DATA_W = 64;

    // Counter width for a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/segled_tick_gen.sv
// segled_tick_gen: divider producing a one-cycle tick every CLK_DIV enabled cycles.
// The counter restarts from zero on reset and on every transfer start, so the
// first tick of a transfer always lands CLK_DIV cycles after the start edge.
module segled_tick_gen
    import segled_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = cnt_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count enabled cycles, wrapping to zero after CLK_DIV-1.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/segled_shifter.sv
// segled_shifter: serial driver for the seven-segment display shift-register chain.
// Accepts a frame over valid/ready, shifts it MSB-first on a divided seg_clk,
// blanks the display during the transfer and re-enables it after a settle time.
// Optional feature: define SEGLED_AUTO_REFRESH_EN to periodically re-send the
// last host frame while idle.
//
// Handshake: a frame is taken on any rising clk edge where load_valid and
// load_ready are both high; load_ready is high exactly when the FSM is IDLE.
// load_valid outside IDLE is ignored and nothing is queued.
module segled_shifter
    import segled_pkg::*;
#(
    parameter int DATA_W         = SEG_DATA_W,
    parameter int CLK_DIV        = 8,
    parameter int REFRESH_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              seg_clk,
    output logic              seg_do,
    output logic              seg_pen,
    output logic              busy
);

    localparam int BW = cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    // FSM state is kept in a plain register so checkers can bind to r_state.
    state_t             r_state;
    // Bits still waiting behind the one currently driven on seg_do.
    logic [DATA_W-2:0]  r_shift;
    logic [BW-1:0]      r_bit_cnt;
    logic               r_seg_clk;
    logic               r_seg_do;
    logic               r_seg_pen;

    logic               w_idle;
    logic               w_host_start;
    logic               w_start;
    logic [DATA_W-1:0]  w_start_data;
    logic               w_tick;

    assign w_idle       = (r_state == IDLE);
    assign w_host_start = load_valid && w_idle;

`ifdef SEGLED_AUTO_REFRESH_EN
    localparam int RW = cnt_w(REFRESH_CYCLES);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    // The held copy only feeds the refresh path, so it exists only in this build.
    logic [DATA_W-1:0]  r_held;
    logic [RW-1:0]      r_refresh_cnt;
    logic               r_have_frame;
    logic               w_refresh_due;

    // A host offer in the expiry cycle wins, so refresh requires load_valid low.
    assign w_refresh_due = w_idle && r_have_frame && !load_valid
                           && (r_refresh_cnt == REFRESH_LAST);
    assign w_start       = w_host_start || w_refresh_due;
    assign w_start_data  = w_host_start ? load_data : r_held;

    // Idle-time counter; wraps so it stays bounded before the first frame arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
        end else if (w_start) begin
            r_refresh_cnt <= '0;
        end else if (w_idle) begin
            if (r_refresh_cnt == REFRESH_LAST) begin
                r_refresh_cnt <= '0;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
        end
    end

    // Remember the last host frame and whether one has ever been accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held       <= '0;
            r_have_frame <= 1'b0;
        end else if (w_host_start) begin
            r_held       <= load_data;
            r_have_frame <= 1'b1;
        end
    end
`else
    assign w_start      = w_host_start;
    assign w_start_data = load_data;
`endif

    segled_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_start),
        .i_en   (!w_idle),
        .o_tick (w_tick)
    );

    // Transfer FSM: load, shift one bit per two tick phases, settle, light display.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_seg_clk <= 1'b0;
            r_seg_do  <= 1'b0;
            r_seg_pen <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state   <= SHIFT;
                        r_shift   <= w_start_data[DATA_W-2:0];
                        r_bit_cnt <= '0;
                        r_seg_clk <= 1'b0;
                        r_seg_do  <= w_start_data[DATA_W-1];
                        r_seg_pen <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (!r_seg_clk) begin
                            // Rising edge: the chain samples the stable seg_do.
                            r_seg_clk <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit or finish.
                            r_seg_clk <= 1'b0;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_state  <= SETTLE;
                                r_seg_do <= 1'b0;
                            end else begin
                                r_seg_do  <= r_shift[DATA_W-2];
                                r_shift   <= {r_shift[DATA_W-3:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (w_tick) begin
                        r_state   <= IDLE;
                        r_seg_pen <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign load_ready = w_idle;
    assign busy       = !w_idle;
    assign seg_clk    = r_seg_clk;
    assign seg_do     = r_seg_do;
    assign seg_pen    = r_seg_pen;

endmodule
